// File: rtl/rv32_pkg.sv
// Shared RV32I constants and types for the memory/writeback stage.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_PC4  = 2'd2,
    WB_LOAD = 2'd3
  } wb_sel_t;

  function automatic wb_sel_t wb_sel(input logic [6:0] opcode);
    wb_sel_t sel;
    case (opcode)
      OPC_LOAD:                                   sel = WB_LOAD;
      OPC_JAL, OPC_JALR:                          sel = WB_PC4;
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM:     sel = WB_ALU;
      default:                                    sel = WB_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/half from the read word and extends it.
module load_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// RV32I memory-access and writeback stage with a request/response data-memory port.
// Optional MEM_MISALIGN_CHECK_EN: misaligned halves/words are dropped and flagged on misalign_err.
module mem_wb_stage
  import rv32_pkg::*;
#(
  parameter int RESP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_Mem,
  input  logic [31:0] pc_Mem,
  input  logic [31:0] inst_Mem,
  input  logic [31:0] alu_out_Mem,
  input  logic [31:0] rs2_Mem,
  output logic        stall_Mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] inst_Wb,
  output logic [31:0] wb_mux_out_Wb,
  output logic        reg_write_en,
  output logic        bus_err
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT) + 1;

  mem_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] inst_wb_q, inst_wb_d;
  logic [31:0] wb_q, wb_d;
  logic        we_q, we_d;
  logic        bus_err_q, bus_err_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_load, is_store, is_mem;
  logic        misaligned;
  logic        retire, timeout, misalign_hit;
  logic [3:0]  be_st;
  logic [31:0] wdata_st;
  logic [31:0] load_data;
  wb_sel_t     sel;

  assign opcode   = inst_Mem[6:0];
  assign funct3   = inst_Mem[14:12];
  assign rd       = inst_Mem[11:7];
  assign is_load  = valid_Mem && (opcode == OPC_LOAD);
  assign is_store = valid_Mem && (opcode == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign sel      = wb_sel(opcode);

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_LH, F3_LHU: misaligned = alu_out_Mem[0];
        F3_LW:         misaligned = (alu_out_Mem[1:0] != 2'b00);
        default:       misaligned = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        F3_SH:   misaligned = alu_out_Mem[0];
        F3_SW:   misaligned = (alu_out_Mem[1:0] != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // Store lanes: halves snap to the half-word boundary, the byte lane follows addr[1:0].
  always_comb begin
    be_st    = 4'b1111;
    wdata_st = rs2_Mem;
    case (funct3)
      F3_SB: begin
        be_st    = 4'b0001 << alu_out_Mem[1:0];
        wdata_st = {4{rs2_Mem[7:0]}};
      end
      F3_SH: begin
        be_st    = alu_out_Mem[1] ? 4'b1100 : 4'b0011;
        wdata_st = {2{rs2_Mem[15:0]}};
      end
      default: begin
        be_st    = 4'b1111;
        wdata_st = rs2_Mem;
      end
    endcase
  end

  assign dmem_req   = !reset && is_mem && !misaligned && (state_q == IDLE || state_q == REQ);
  assign dmem_we    = dmem_req && is_store;
  assign dmem_be    = dmem_req ? (is_store ? be_st : 4'b1111) : 4'b0000;
  assign dmem_addr  = {alu_out_Mem[31:2], 2'b00};
  assign dmem_wdata = wdata_st;

  load_align u_load_align (
    .funct3  (funct3),
    .addr_lo (alu_out_Mem[1:0]),
    .rdata   (dmem_rdata),
    .result  (load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retire       = 1'b0;
    timeout      = 1'b0;
    misalign_hit = 1'b0;
    case (state_q)
      IDLE, REQ: begin
        if (is_mem && !misaligned) begin
          if (dmem_ready) begin
            if (is_store) begin
              retire  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_W'(RESP_TIMEOUT - 1);
            end
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d      = IDLE;
          retire       = valid_Mem && !is_mem;
          misalign_hit = is_mem && misaligned;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          retire  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_Mem = !reset && is_mem && !(retire || timeout || misalign_hit);

  // Anything not retiring normally (stall, bubble, timeout, misalign) writes a NOP.
  always_comb begin
    inst_wb_d = NOP_INST;
    wb_d      = wb_q;
    we_d      = 1'b0;
    if (retire) begin
      inst_wb_d = inst_Mem;
      case (sel)
        WB_ALU:  wb_d = alu_out_Mem;
        WB_PC4:  wb_d = pc_Mem + 32'd4;
        WB_LOAD: wb_d = load_data;
        default: wb_d = wb_q;
      endcase
      we_d = (sel != WB_NONE) && (rd != 5'd0);
    end
    bus_err_d = timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      inst_wb_q <= NOP_INST;
      wb_q      <= '0;
      we_q      <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inst_wb_q <= inst_wb_d;
      wb_q      <= wb_d;
      we_q      <= we_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_hit;
    end
  end

  assign misalign_err = misalign_q;
`endif

  assign inst_Wb       = inst_wb_q;
  assign wb_mux_out_Wb = wb_q;
  assign reg_write_en  = we_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage: expected retirements are queued at issue
// and popped whenever a non-NOP instruction appears on the WB outputs.
module tb_mem_wb_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [6:0]  LOAD   = 7'b0000011;
  localparam logic [6:0]  STORE  = 7'b0100011;
  localparam logic [6:0]  JAL    = 7'b1101111;
  localparam logic [6:0]  JALR   = 7'b1100111;
  localparam logic [6:0]  LUI    = 7'b0110111;
  localparam logic [6:0]  AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP     = 7'b0110011;
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  BRANCH = 7'b1100011;
  localparam logic [6:0]  SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_Mem;
  logic [31:0] pc_Mem, inst_Mem, alu_out_Mem, rs2_Mem;
  logic        stall_Mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] inst_Wb, wb_mux_out_Wb;
  logic        reg_write_en, bus_err;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [31:0] wb;
    logic        we;
  } wb_exp_t;

  wb_exp_t     sb_q[$];
  logic [31:0] last_wb;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.RESP_TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_Mem     (valid_Mem),
    .pc_Mem        (pc_Mem),
    .inst_Mem      (inst_Mem),
    .alu_out_Mem   (alu_out_Mem),
    .rs2_Mem       (rs2_Mem),
    .stall_Mem     (stall_Mem),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ready    (dmem_ready),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .inst_Wb       (inst_Wb),
    .wb_mux_out_Wb (wb_mux_out_Wb),
    .reg_write_en  (reg_write_en),
    .bus_err       (bus_err)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
    return {17'h0, f3, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock; WB outputs are sampled 1 time unit after the edge.
  task automatic tick();
    wb_exp_t e;
    @(posedge clk);
    #1;
    if (inst_Wb !== NOP) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_retire", inst_Wb, NOP);
      end else begin
        e = sb_q.pop_front();
        chk("wb_inst", inst_Wb, e.inst);
        chk("wb_value", wb_mux_out_Wb, e.wb);
        chk("wb_we", 32'(reg_write_en), 32'(e.we));
      end
    end else begin
      chk("bubble_we", 32'(reg_write_en), 32'd0);
    end
  endtask

  task automatic do_op(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] exp_wb, input logic exp_we);
    wb_exp_t e;
    valid_Mem = 1'b1; inst_Mem = mk(op, rd, 3'b000); pc_Mem = pc; alu_out_Mem = alu;
    #1;
    chk("op_stall", 32'(stall_Mem), 32'd0);
    chk("op_req", 32'(dmem_req), 32'd0);
    e.inst = inst_Mem; e.wb = exp_wb; e.we = exp_we;
    sb_q.push_back(e);
    last_wb = exp_wb;
    tick();
    valid_Mem = 1'b0;
    chk("op_retired", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] rdata_v, input logic [31:0] exp_v, input int rdly, input int lat);
    wb_exp_t e;
    valid_Mem = 1'b1; inst_Mem = mk(LOAD, rd, f3); alu_out_Mem = addr;
    e.inst = inst_Mem; e.wb = exp_v; e.we = (rd != 5'd0);
    sb_q.push_back(e);
    last_wb = exp_v;
    for (int i = 0; i <= rdly; i++) begin
      dmem_ready = (i == rdly); dmem_rvalid = (i != rdly); dmem_rdata = 32'hDEAD_DEAD;
      #1;
      chk("ld_req", 32'(dmem_req), 32'd1);
      chk("ld_we", 32'(dmem_we), 32'd0);
      chk("ld_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("ld_stall_req", 32'(stall_Mem), 32'd1);
      tick();
    end
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    for (int i = 1; i < lat; i++) begin
      #1;
      chk("ld_stall_wait", 32'(stall_Mem), 32'd1);
      chk("ld_req_wait", 32'(dmem_req), 32'd0);
      tick();
    end
    dmem_rvalid = 1'b1; dmem_rdata = rdata_v;
    #1;
    chk("ld_stall_rvalid", 32'(stall_Mem), 32'd0);
    tick();
    dmem_rvalid = 1'b0; valid_Mem = 1'b0;
    chk("ld_retired", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input int rdly);
    wb_exp_t e;
    valid_Mem = 1'b1; inst_Mem = mk(STORE, 5'd3, f3); alu_out_Mem = addr; rs2_Mem = rs2;
    e.inst = inst_Mem; e.wb = last_wb; e.we = 1'b0;
    sb_q.push_back(e);
    for (int i = 0; i <= rdly; i++) begin
      dmem_ready = (i == rdly);
      #1;
      chk("st_req", 32'(dmem_req), 32'd1);
      chk("st_we", 32'(dmem_we), 32'd1);
      chk("st_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("st_be", 32'(dmem_be), 32'(exp_be));
      chk("st_wdata", dmem_wdata, exp_wd);
      chk("st_stall", 32'(stall_Mem), 32'(i != rdly));
      tick();
    end
    dmem_ready = 1'b0; valid_Mem = 1'b0;
    chk("st_retired", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inst"}, inst_Wb, NOP);
    chk({tag, "_wb"}, wb_mux_out_Wb, 32'd0);
    chk({tag, "_we"}, 32'(reg_write_en), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_stall"}, 32'(stall_Mem), 32'd0);
    chk({tag, "_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_be"}, 32'(dmem_be), 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk({tag, "_misalign"}, 32'(misalign_err), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid_Mem = 1'b0; pc_Mem = '0; inst_Mem = NOP; alu_out_Mem = '0;
    rs2_Mem = '0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; last_wb = '0;
    tick(); tick();
    // valid_Mem with a store during reset must not request
    valid_Mem = 1'b1; inst_Mem = mk(STORE, 5'd0, 3'b010);
    #1;
    chk_reset_outputs("rst");
    tick();
    valid_Mem = 1'b0; reset = 1'b0;
    tick();

    // non-memory classes, several back to back
    do_op(OP_IMM, 5'd5, 32'h0000_0000, 32'h0000_1234, 32'h0000_1234, 1'b1);
    do_op(JAL,    5'd1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0044, 1'b1);
    do_op(JAL,    5'd0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0044, 1'b0);
    do_op(JALR,   5'd9, 32'h0000_0100, 32'h0000_0777, 32'h0000_0104, 1'b1);
    do_op(LUI,    5'd10, 32'h0000_0000, 32'hABCD_E000, 32'hABCD_E000, 1'b1);
    do_op(BRANCH, 5'd11, 32'h0000_0200, 32'h0000_5555, last_wb, 1'b0);
    do_op(AUIPC,  5'd12, 32'h0000_0300, 32'h1000_0300, 32'h1000_0300, 1'b1);
    do_op(SYSTEM, 5'd13, 32'h0000_0304, 32'h0000_9999, last_wb, 1'b0);
    do_op(OP,     5'd31, 32'h0000_0308, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();

    // loads: lane select and extension
    do_load(3'b000, 5'd6,  32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80, 0, 2);
    do_load(3'b001, 5'd7,  32'h0000_0102, 32'h8001_7F00, 32'hFFFF_8001, 0, 1);
    do_load(3'b101, 5'd7,  32'h0000_0102, 32'h8001_7F00, 32'h0000_8001, 2, 3);
    do_load(3'b100, 5'd8,  32'h0000_0101, 32'h0000_9900, 32'h0000_0099, 0, 1);
    do_load(3'b001, 5'd8,  32'h0000_0100, 32'h1234_7F00, 32'h0000_7F00, 1, 1);
    do_load(3'b010, 5'd0,  32'h0000_0104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1);
    tick();

    // stores: byte enables and lane replication
    do_store(3'b001, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 3);
    do_store(3'b000, 32'h0000_0301, 32'h0000_0055, 4'b0010, 32'h5555_5555, 0);
    do_store(3'b001, 32'h0000_0300, 32'h0000_BEEF, 4'b0011, 32'hBEEF_BEEF, 0);
    do_store(3'b010, 32'h0000_0304, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1);
    tick();

    // load timeout: 16 WAIT cycles, then a single bus_err pulse and no write
    valid_Mem = 1'b1; inst_Mem = mk(LOAD, 5'd4, 3'b010); alu_out_Mem = 32'h0000_0400;
    dmem_ready = 1'b1;
    #1;
    chk("to_accept_req", 32'(dmem_req), 32'd1);
    tick();
    dmem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk("to_stall", 32'(stall_Mem), 32'(i < 16));
      chk("to_req", 32'(dmem_req), 32'd0);
      tick();
      chk("to_bus_err", 32'(bus_err), 32'(i == 16));
    end
    valid_Mem = 1'b0;
    tick();
    chk("to_bus_err_clear", 32'(bus_err), 32'd0);
    // back in IDLE: the next load requests immediately
    do_load(3'b010, 5'd4, 32'h0000_0400, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 1);

    // reset while waiting for a response; the late rvalid must be discarded
    valid_Mem = 1'b1; inst_Mem = mk(LOAD, 5'd7, 3'b010); alu_out_Mem = 32'h0000_0080;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("rw_stall", 32'(stall_Mem), 32'd1);
    tick();
    reset = 1'b1; valid_Mem = 1'b0;
    tick(); tick();
    reset = 1'b0; last_wb = '0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    chk_reset_outputs("rw_late1");
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk_reset_outputs("rw_late2");
    do_op(OP_IMM, 5'd2, 32'h0000_0500, 32'h0000_0042, 32'h0000_0042, 1'b1);

`ifdef MEM_MISALIGN_CHECK_EN
    valid_Mem = 1'b1; inst_Mem = mk(LOAD, 5'd8, 3'b010); alu_out_Mem = 32'h0000_0101;
    dmem_ready = 1'b1;
    #1;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(stall_Mem), 32'd0);
    tick();
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    valid_Mem = 1'b0; dmem_ready = 1'b0;
    tick();
    chk("mis_clear", 32'(misalign_err), 32'd0);
`else
    do_load(3'b010, 5'd8, 32'h0000_0101, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 1);
`endif

    tick();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
